run_ctrl: RTL and testbench

Processor-side responder for the Start/Ack launch handshake that the top-level bench drives. It sits inside TopLevel between the Start/Ack pins and the program counter. It arms on a Start pulse and loads the PC with the base address of the next program (P1, P2, P3 in rotation). It then enables execution until the decoder reports a halt, and raises Ack with a cycle count for diagnostics.

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/sat_counter.sv | 41 ++++
 rtl/run_ctrl.sv | 124 ++++++++++++
 tb/tb_run_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the Start/Ack launch controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Holds the state encoding, the program base-address map (also used to lay out
// the instruction ROM image) and the default cycle-counter width.
package run_ctrl_pkg;

   localparam int PC_W_DEF  = 10;
   localparam int CNT_W_DEF = 16;

   // State encoding kept as plain constants so legacy tools can read it.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_ARMED = 3'd1;
   localparam state_t ST_LOAD  = 3'd2;
   localparam state_t ST_RUN   = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Base addresses of P1, P2, P3. The fourth slot is only reached when the
   // rotation is configured for four programs.
   localparam logic [PC_W_DEF-1:0] PROG_BASE [4] = '{10'h000, 10'h100, 10'h200, 10'h300};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; holds at all-ones once reached.
//
// Ports: clk_i/rst_i clock and sync active-high reset, clr_i clear to zero,
//        en_i count enable, cnt_o current count, max_o count is all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         max_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign max_o = &cnt_q;
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !max_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Launch controller: arms on Start, loads PC with the next program base, runs until Halt, raises Ack.
// Latency: PcLoad 1 cycle after Start falls is sampled; Ack in the cycle after Halt is sampled in RUN.
// Backpressure: Start ignored outside IDLE/ARMED/DONE; one launch per Start pulse.
//
// Ports: Clk, Reset (sync, active-high), Start (level, launches on fall), Halt (decoder done flag),
//        PcLoad/PcLoadAddr (PC load strobe and address), Run (execute enable), ProgIdx (current/last
//        program), CycleCnt (Run cycles of current/last program), Ack (done), Timeout (watchdog fired).
// Optional watchdog compiled in with RUN_CTRL_WATCHDOG_EN; otherwise Timeout is tied low.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int               PC_W       = PC_W_DEF,
   parameter int               CNT_W      = CNT_W_DEF,
   parameter int               NUM_PROGS  = 3,
   parameter logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(16'hFFF0)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halt,
   output logic             PcLoad,
   output logic [PC_W-1:0]  PcLoadAddr,
   output logic             Run,
   output logic [1:0]       ProgIdx,
   output logic [CNT_W-1:0] CycleCnt,
   output logic             Ack,
   output logic             Timeout
);

   state_t     state_q, state_d;
   logic [1:0] prog_idx_q, prog_idx_d;
   logic       cnt_max;

   // Run, PcLoad and Ack come straight from the state register so they never glitch.
   assign Run        = (state_q == ST_RUN);
   assign PcLoad     = (state_q == ST_LOAD);
   assign Ack        = (state_q == ST_DONE);
   assign ProgIdx    = prog_idx_q;
   assign PcLoadAddr = PC_W'(PROG_BASE[prog_idx_q]);

   // The count is cleared during LOAD so the first RUN cycle starts from zero;
   // every RUN cycle, including the halt cycle, is counted.
   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk_i (Clk),
      .rst_i (Reset),
      .clr_i (state_q == ST_LOAD),
      .en_i  (state_q == ST_RUN),
      .cnt_o (CycleCnt),
      .max_o (cnt_max)
   );

`ifdef RUN_CTRL_WATCHDOG_EN
   logic timeout_q, timeout_d;
   logic wdog_hit;

   // Fire on the edge where the count lands on the limit, so the block leaves
   // RUN with CycleCnt equal to WDOG_LIMIT. An all-ones limit is caught by the
   // saturation flag instead, since the count can never step past it.
   assign wdog_hit = (WDOG_LIMIT == '1) ? cnt_max
                                        : (CycleCnt == WDOG_LIMIT - CNT_W'(1));
   assign Timeout  = timeout_q;
`else
   logic unused_wdog;
   assign unused_wdog = ^{WDOG_LIMIT, cnt_max};
   assign Timeout     = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      prog_idx_d = prog_idx_q;
`ifdef RUN_CTRL_WATCHDOG_EN
      timeout_d  = timeout_q;
`endif
      case (state_q)
         ST_IDLE:  if (Start) state_d = ST_ARMED;
         ST_ARMED: if (!Start) state_d = ST_LOAD;
         ST_LOAD: begin
            state_d = ST_RUN;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_d = 1'b0;
`endif
         end
         ST_RUN: begin
            // Halt wins over a simultaneous Start; Start is not latched here.
            if (Halt) begin
               state_d = ST_DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
            end else if (wdog_hit) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
`endif
            end
         end
         ST_DONE: begin
            if (Start) begin
               state_d    = ST_ARMED;
               prog_idx_d = (prog_idx_q == 2'(NUM_PROGS - 1)) ? 2'd0 : prog_idx_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         prog_idx_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         prog_idx_q <= prog_idx_d;
      end
   end

`ifdef RUN_CTRL_WATCHDOG_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: randomized launches with a launch-level reference model and a scoreboard monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int PC_W      = 10;
   localparam int CNT_W     = 16;
   localparam int NUM_PROGS = 3;

   logic             clk;
   logic             Reset;
   logic             Start;
   logic             Halt;
   logic             PcLoad;
   logic [PC_W-1:0]  PcLoadAddr;
   logic             Run;
   logic [1:0]       ProgIdx;
   logic [CNT_W-1:0] CycleCnt;
   logic             Ack;
   logic             Timeout;

   run_ctrl #(
      .PC_W       (PC_W),
      .CNT_W      (CNT_W),
      .NUM_PROGS  (NUM_PROGS),
      .WDOG_LIMIT (16'd20)
   ) dut (
      .Clk        (clk),
      .Reset      (Reset),
      .Start      (Start),
      .Halt       (Halt),
      .PcLoad     (PcLoad),
      .PcLoadAddr (PcLoadAddr),
      .Run        (Run),
      .ProgIdx    (ProgIdx),
      .CycleCnt   (CycleCnt),
      .Ack        (Ack),
      .Timeout    (Timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One entry per launch: what the program run should look like.
   typedef struct {
      int idx;
      int addr;
      int cycles;   // -1: never completes
      int tmo;
   } exp_t;

   exp_t exp_q[$];
   int   launches;
   int   errors;
   int   checks;

   function automatic void chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endfunction

   // Reference model: the n-th launch since reset runs program n mod NUM_PROGS.
   function automatic void expect_launch(input int cycles, input int tmo);
      exp_t e;
      e.idx    = launches % NUM_PROGS;
      e.addr   = int'(PROG_BASE[e.idx]);
      e.cycles = (cycles > 65535) ? 65535 : cycles;
      e.tmo    = tmo;
      exp_q.push_back(e);
      launches++;
   endfunction

   // Monitor: samples 1 time unit after each rising edge.
   initial begin : monitor
      bit ack_prev;
      bit in_flight;
      int run_cnt;
      exp_t e;
      ack_prev  = 1'b0;
      in_flight = 1'b0;
      run_cnt   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (Reset) begin
            ack_prev  = 1'b0;
            in_flight = 1'b0;
            continue;
         end
         if (PcLoad) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pcload", 1, 0);
            end else begin
               e = exp_q[0];
               chk("pcload_addr", PcLoadAddr, e.addr);
               chk("pcload_idx", ProgIdx, e.idx);
               in_flight = 1'b1;
               run_cnt   = 0;
            end
         end
         if (Run) run_cnt++;
         if (Ack && !ack_prev) begin
            if (!in_flight || exp_q.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_cyclecnt", CycleCnt, e.cycles);
               chk("done_run_cycles", run_cnt, e.cycles);
               chk("done_progidx", ProgIdx, e.idx);
               chk("done_timeout", Timeout, e.tmo);
               in_flight = 1'b0;
            end
         end
         ack_prev = Ack;
      end
   end

   task automatic do_reset(input int cyc);
      @(negedge clk);
      Reset = 1'b1;
      Start = 1'b0;
      Halt  = 1'b0;
      exp_q.delete();
      launches = 0;
      repeat (cyc) @(negedge clk);
      Reset = 1'b0;
   endtask

   // Pulse Start for slen cycles and wait for RUN; returns 1 once Run is seen.
   task automatic start_pulse(input int slen, input int cycles, input int tmo, output bit got);
      bit was_ack;
      @(negedge clk);
      was_ack = Ack;
      Start   = 1'b1;
      for (int i = 0; i < slen; i++) begin
         @(negedge clk);
         if (i == 0 && was_ack) chk("ack_drop_on_start", Ack, 0);
      end
      expect_launch(cycles, tmo);
      Start = 1'b0;
      got   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (Run) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("run_start_timeout", 0, 1);
   endtask

   // Full launch, Halt asserted in RUN cycle n (optionally together with Start).
   task automatic launch(input int n, input int slen, input bit combo);
      bit got;
      start_pulse(slen, n, 0, got);
      if (got) begin
         for (int k = 1; k < n; k++) @(negedge clk);
         Halt = 1'b1;
         if (combo) Start = 1'b1;
         @(negedge clk);
         Halt  = 1'b0;
         Start = 1'b0;
         chk("ack_after_halt", Ack, 1);
      end
   endtask

   initial begin
      bit got;
      int n;
      Reset    = 1'b1;
      Start    = 1'b0;
      Halt     = 1'b0;
      errors   = 0;
      checks   = 0;
      launches = 0;

      // Reset held 2 cycles, then release and look at every output.
      do_reset(2);
      @(negedge clk);
      chk("rst_pcload", PcLoad, 0);
      chk("rst_pcloadaddr", PcLoadAddr, PROG_BASE[0]);
      chk("rst_run", Run, 0);
      chk("rst_progidx", ProgIdx, 0);
      chk("rst_cyclecnt", CycleCnt, 0);
      chk("rst_ack", Ack, 0);
      chk("rst_timeout", Timeout, 0);
      repeat (3) @(negedge clk);
      chk("idle_no_ack", Ack, 0);

      // Basic launch: 5 RUN cycles on P1.
      launch(5, 1, 1'b0);

      // Randomized back-to-back launches; covers rotation and wrap to P1.
      for (int i = 0; i < 8; i++) begin
         launch($urandom_range(1, 12), $urandom_range(1, 3), 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Minimum launch-to-Ack: Halt in the first RUN cycle.
      launch(1, 1, 1'b0);

      // Halt and Start together in RUN: Halt wins, no relaunch follows.
      n = $urandom_range(2, 6);
      launch(n, 1, 1'b1);
      repeat (5) @(negedge clk);
      chk("combo_ack_held", Ack, 1);
      chk("combo_cnt_held", CycleCnt, n);
      chk("combo_no_pcload", PcLoad, 0);

      // Fresh pulse after the combo still launches normally.
      launch(3, 2, 1'b0);

      // Reset in RUN cycle 3.
      start_pulse(1, -1, 0, got);
      if (got) begin
         repeat (2) @(negedge clk);
         Reset = 1'b1;
         exp_q.delete();
         launches = 0;
         @(negedge clk);
         chk("midrst_run", Run, 0);
         chk("midrst_ack", Ack, 0);
         chk("midrst_progidx", ProgIdx, 0);
         chk("midrst_pcload", PcLoad, 0);
         Reset = 1'b0;
      end

      // After reset the rotation restarts at P1.
      launch(4, 1, 1'b0);
      launch(2, 1, 1'b0);

      // Program with no halt.
`ifdef RUN_CTRL_WATCHDOG_EN
      start_pulse(1, 20, 1, got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (Ack) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("wdog_ack", got, 1);
      chk("wdog_timeout", Timeout, 1);
      chk("wdog_cyclecnt", CycleCnt, 20);
`else
      start_pulse(1, -1, 0, got);
      if (got) begin
         repeat (100) @(negedge clk);
         chk("nohalt_run", Run, 1);
         chk("nohalt_ack", Ack, 0);
         chk("nohalt_timeout", Timeout, 0);
         chk("nohalt_cyclecnt", CycleCnt, 100);
      end
      do_reset(2);
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
      $fatal(1);
   end

endmodule
